// File: rtl/sdram_block_responder.sv
// Word-at-a-time SDRAM stand-in for a cache controller: accepts strobed read/write beats,
// answers after LATENCY cycles, and flags protocol violations in a sticky err bit.
module sdram_block_responder #(
  parameter int BLOCKSIZE_W = 5,
  parameter int BLK_ADDR_W  = 8,
  parameter int DATA_W      = 8,
  parameter int LATENCY     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memstrb,
  input  logic                   wr_rd_sdram,
  input  logic [BLK_ADDR_W-1:0]  blk_addr,
  input  logic [BLOCKSIZE_W-1:0] addr_offset_counter,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   dvalid,
  output logic                   wack,
  output logic                   block_done,
  output logic                   busy,
  output logic                   err
);

  localparam int ADDR_W = BLK_ADDR_W + BLOCKSIZE_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] LAT_INIT = 3'(LATENCY);
  localparam logic [BLOCKSIZE_W-1:0] OFF_ZERO = {BLOCKSIZE_W{1'b0}};
  localparam logic [BLOCKSIZE_W-1:0] OFF_ONE  = {{(BLOCKSIZE_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                 state_r;
  logic                   memstrb_q_r;
  logic [2:0]             lat_cnt_r;
  logic [BLOCKSIZE_W-1:0] beat_r;
  logic                   cap_wr_r;
  logic [BLK_ADDR_W-1:0]  cap_addr_r;
  logic [BLOCKSIZE_W-1:0] cap_off_r;
  logic [DATA_W-1:0]      cap_din_r;
  logic [DATA_W-1:0]      dout_r;
  logic                   dvalid_r;
  logic                   wack_r;
  logic                   block_done_r;
  logic                   busy_r;
  logic                   err_r;
  logic [DATA_W-1:0]      mem_r [0:DEPTH-1];

  logic                   strobe_edge_s;
  logic                   accept_s;
  logic                   access_s;
  logic                   proto_err_s;
  logic [ADDR_W-1:0]      mem_idx_s;

  assign strobe_edge_s = memstrb & ~memstrb_q_r;
  assign accept_s      = strobe_edge_s & (state_r == IDLE);
  assign access_s      = (state_r == WAIT) & (lat_cnt_r == 3'd1);
  assign mem_idx_s     = {cap_addr_r, cap_off_r};

  // Protocol-violation detection for the current edge
  always_comb begin
    proto_err_s = 1'b0;
    if (strobe_edge_s && (state_r == WAIT)) begin
      proto_err_s = 1'b1;
    end else if (accept_s && (addr_offset_counter != beat_r)) begin
      proto_err_s = 1'b1;
    end else if (accept_s && (beat_r != OFF_ZERO) &&
                 ((wr_rd_sdram != cap_wr_r) || (blk_addr != cap_addr_r))) begin
      // a block in progress must keep direction and block address
      proto_err_s = 1'b1;
    end else begin
      proto_err_s = 1'b0;
    end
  end

  // Control FSM, capture registers and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      memstrb_q_r  <= 1'b0;
      lat_cnt_r    <= 3'd0;
      beat_r       <= OFF_ZERO;
      cap_wr_r     <= 1'b0;
      cap_addr_r   <= {BLK_ADDR_W{1'b0}};
      cap_off_r    <= OFF_ZERO;
      cap_din_r    <= {DATA_W{1'b0}};
      dout_r       <= {DATA_W{1'b0}};
      dvalid_r     <= 1'b0;
      wack_r       <= 1'b0;
      block_done_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      memstrb_q_r  <= memstrb;
      dvalid_r     <= 1'b0;
      wack_r       <= 1'b0;
      block_done_r <= 1'b0;
      if (proto_err_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cap_wr_r   <= wr_rd_sdram;
            cap_addr_r <= blk_addr;
            cap_off_r  <= addr_offset_counter;
            cap_din_r  <= din;
            lat_cnt_r  <= LAT_INIT;
            busy_r     <= 1'b1;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (access_s) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            lat_cnt_r    <= 3'd0;
            block_done_r <= &cap_off_r;
            // expected offset follows the captured one, even after a skip
            beat_r       <= cap_off_r + OFF_ONE;
            if (cap_wr_r) begin
              wack_r <= 1'b1;
            end else begin
              dvalid_r <= 1'b1;
              dout_r   <= mem_r[mem_idx_s];
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (access_s && cap_wr_r && !rst) begin
      mem_r[mem_idx_s] <= cap_din_r;
    end
  end

  assign dout       = dout_r;
  assign dvalid     = dvalid_r;
  assign wack       = wack_r;
  assign block_done = block_done_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sdram_block_responder.sv
// Directed, table-driven bench for sdram_block_responder (LATENCY=1 and LATENCY=3 instances).
module tb_sdram_block_responder;

  logic       clk;
  logic       rst, memstrb, wr_rd_sdram;
  logic [7:0] blk_addr, din, dout;
  logic [4:0] addr_offset_counter;
  logic       dvalid, wack, block_done, busy, err;

  logic       rst3, memstrb3, wr3;
  logic [7:0] addr3, din3, dout3;
  logic [4:0] off3;
  logic       dvalid3, wack3, done3, busy3, err3;

  int checks;
  int failures;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [4:0] off;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_dvalid;
    logic       exp_wack;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs [64];

  sdram_block_responder #(.BLOCKSIZE_W(5), .BLK_ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .memstrb(memstrb), .wr_rd_sdram(wr_rd_sdram),
    .blk_addr(blk_addr), .addr_offset_counter(addr_offset_counter), .din(din),
    .dout(dout), .dvalid(dvalid), .wack(wack), .block_done(block_done),
    .busy(busy), .err(err)
  );

  sdram_block_responder #(.BLOCKSIZE_W(5), .BLK_ADDR_W(8), .DATA_W(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .memstrb(memstrb3), .wr_rd_sdram(wr3),
    .blk_addr(addr3), .addr_offset_counter(off3), .din(din3),
    .dout(dout3), .dvalid(dvalid3), .wack(wack3), .block_done(done3),
    .busy(busy3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One beat on the LATENCY=1 instance; called and returns at a negedge.
  task automatic do_beat(input vec_t v, input string tag);
    wr_rd_sdram         = v.wr;
    blk_addr            = v.addr;
    addr_offset_counter = v.off;
    din                 = v.din;
    memstrb             = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memstrb = 1'b0;
    chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    chk({tag, "_dvalid_wait"}, 32'(dvalid), 32'd0);
    chk({tag, "_wack_wait"}, 32'(wack), 32'd0);
    chk({tag, "_err_accept"}, 32'(err), 32'(v.exp_err));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_dout"}, 32'(dout), 32'(v.exp_dout));
    chk({tag, "_dvalid"}, 32'(dvalid), 32'(v.exp_dvalid));
    chk({tag, "_wack"}, 32'(wack), 32'(v.exp_wack));
    chk({tag, "_block_done"}, 32'(block_done), 32'(v.exp_done));
    chk({tag, "_busy_resp"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [4:0] off,
                              input logic [7:0] d, input logic [7:0] edout,
                              input logic edv, input logic ewk, input logic edn, input logic eer);
    vec_t v;
    v.wr = wr; v.addr = addr; v.off = off; v.din = d; v.exp_dout = edout;
    v.exp_dvalid = edv; v.exp_wack = ewk; v.exp_done = edn; v.exp_err = eer;
    return v;
  endfunction

  initial begin
    int wcnt;
    int found;
    logic [7:0] pat;
    checks = 0; failures = 0;
    rst = 1'b1; memstrb = 1'b0; wr_rd_sdram = 1'b0; blk_addr = 8'h00;
    addr_offset_counter = 5'd0; din = 8'h00;
    rst3 = 1'b1; memstrb3 = 1'b0; wr3 = 1'b0; addr3 = 8'h00; off3 = 5'd0; din3 = 8'h00;

    // block write then read-back of block 0x12, data = offset ^ 0xA5
    for (int i = 0; i < 32; i++) begin
      pat = 8'(i) ^ 8'hA5;
      vecs[i]      = mk(1'b1, 8'h12, 5'(i), pat, 8'h00, 1'b0, 1'b1, (i == 31), 1'b0);
      vecs[32 + i] = mk(1'b0, 8'h12, 5'(i), 8'h00, pat, 1'b1, 1'b0, (i == 31), 1'b0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_wack", 32'(wack), 32'd0);
    chk("rst_block_done", 32'(block_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    rst = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 64; i++) begin
      do_beat(vecs[i], $sformatf("v%0d", i));
    end

    // reset in the cycle after a write accept aborts the write
    wr_rd_sdram = 1'b1; blk_addr = 8'h12; addr_offset_counter = 5'd5; din = 8'hFF;
    memstrb = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1; memstrb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wack", 32'(wack), 32'd0);
    chk("abort_dvalid", 32'(dvalid), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_done", 32'(block_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_wack_late", 32'(wack), 32'd0);
    // offset 5 against expected 0 flags err, data must still be the old value
    do_beat(mk(1'b0, 8'h12, 5'd5, 8'h00, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1), "abort_rd");

    // memstrb held high through reset release and for 4 cycles: one access only
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_rd_sdram = 1'b1; blk_addr = 8'h20; addr_offset_counter = 5'd0; din = 8'h77;
    memstrb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) chk("hold_busy", 32'(busy), 32'd1);
      if (wack) wcnt++;
    end
    memstrb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (wack) wcnt++;
    end
    chk("hold_wack_count", 32'(wcnt), 32'd1);
    chk("hold_err", 32'(err), 32'd0);
    do_beat(mk(1'b0, 8'h20, 5'd0, 8'h00, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1), "hold_rd");

    // skipped offset: 0,1,3
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_beat(mk(1'b1, 8'h40, 5'd0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), "skip0");
    do_beat(mk(1'b1, 8'h40, 5'd1, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), "skip1");
    do_beat(mk(1'b1, 8'h40, 5'd3, 8'h13, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1), "skip3");
    chk("skip_next_beat", 32'(dut.beat_r), 32'd4);
    do_beat(mk(1'b0, 8'h40, 5'd3, 8'h00, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1), "skip_rd");

    // LATENCY=3: second strobe edge while busy is dropped
    @(negedge clk);
    wr3 = 1'b1; addr3 = 8'h01; off3 = 5'd0; din3 = 8'h11; memstrb3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memstrb3 = 1'b0;
    chk("l3_busy_e0", 32'(busy3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("l3_err_before", 32'(err3), 32'd0);
    chk("l3_busy_e1", 32'(busy3), 32'd1);
    off3 = 5'd1; din3 = 8'h22; memstrb3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memstrb3 = 1'b0;
    chk("l3_err_after", 32'(err3), 32'd1);
    chk("l3_wack_early", 32'(wack3), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("l3_wack", 32'(wack3), 32'd1);
    chk("l3_busy_resp", 32'(busy3), 32'd0);
    wcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (wack3) wcnt++;
    end
    chk("l3_extra_wack", 32'(wcnt), 32'd0);
    wr3 = 1'b0; off3 = 5'd0; memstrb3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memstrb3 = 1'b0;
    found = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dvalid3 && found == 0) begin
        found = 1;
        chk("l3_rd_dout", 32'(dout3), 32'h11);
        chk("l3_rd_cycle", 32'(k), 32'd2);
      end
    end
    chk("l3_rd_seen", 32'(found), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
